// File: rtl/ts_multi_gen.sv
// ts_multi_gen: multi-channel MPEG-TS pattern generator, round-robin PIDs with per-channel continuity counters.
// Define TS_NULL_INSERT_EN to insert a null packet (PID 0x1FFF) after every N_CH-th data packet.
module ts_multi_gen #(
  parameter int unsigned N_CH     = 4,
  parameter logic [12:0] BASE_PID = 13'h1000,
  parameter int unsigned PKT_LEN  = 188,
  parameter int unsigned GAP      = 4,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  output logic [7:0] DATA,
  output logic       D_CLK,
  output logic       D_VALID,
  output logic       P_SYNC,
  output logic [3:0] CH_OUT
);

  localparam int unsigned    DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [7:0]     LAST_BYTE = 8'(PKT_LEN - 1);
  localparam logic [7:0]     LAST_GAP  = 8'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [3:0]     LAST_CH   = 4'(N_CH - 1);
  localparam bit             GAP_EN    = (GAP != 0);
  localparam logic [12:0]    NULL_PID  = 13'h1FFF;
`ifdef TS_NULL_INSERT_EN
  localparam bit             NULL_EN   = 1'b1;
`else
  localparam bit             NULL_EN   = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             slot_tick;
  logic [7:0]       byte_cnt, byte_nxt;
  logic [7:0]       gap_cnt, gap_nxt;
  logic [3:0]       ch_ptr, ptr_nxt, ch_nxt;
  logic [3:0]       cc     [16];
  logic [3:0]       cc_nxt [16];
  logic             null_due, null_due_nxt;
  logic             null_cur, null_cur_nxt;
  logic             pkt_end, start;
  logic [12:0]      pid;
  logic [3:0]       cc_sel;
  logic [7:0]       data_nxt;
  logic             valid_nxt, sync_nxt;

  assign slot_tick = (div_cnt == DIV_LAST);
  assign div_nxt   = slot_tick ? '0 : div_cnt + DIV_W'(1);

  // Slot sequencing: decides what the upcoming byte slot carries.
  always_comb begin
    state_nxt    = state;
    byte_nxt     = byte_cnt;
    gap_nxt      = gap_cnt;
    ptr_nxt      = ch_ptr;
    cc_nxt       = cc;
    ch_nxt       = CH_OUT;
    null_due_nxt = null_due;
    null_cur_nxt = null_cur;
    pkt_end      = 1'b0;
    start        = 1'b0;

    case (state)
      S_IDLE: start = EN;
      S_HEADER, S_PAYLOAD, S_PARITY: begin
        if (byte_cnt == LAST_BYTE) begin
          pkt_end = 1'b1;
          if (GAP_EN) begin
            state_nxt = S_GAP;
            gap_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
            start     = EN;
          end
        end else begin
          byte_nxt = byte_cnt + 8'd1;
          if (byte_nxt >= 8'd188)
            state_nxt = S_PARITY;
          else if (byte_nxt >= 8'd4)
            state_nxt = S_PAYLOAD;
          else
            state_nxt = S_HEADER;
        end
      end
      S_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_nxt = S_IDLE;
          start     = EN;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Null packets leave the pointer and every CC untouched.
    if (pkt_end && !null_cur) begin
      cc_nxt[ch_ptr] = cc[ch_ptr] + 4'd1;
      if (ch_ptr == LAST_CH) begin
        ptr_nxt      = '0;
        null_due_nxt = NULL_EN;
      end else begin
        ptr_nxt = ch_ptr + 4'd1;
      end
    end

    if (start) begin
      state_nxt    = S_HEADER;
      byte_nxt     = '0;
      null_cur_nxt = null_due_nxt;
      null_due_nxt = 1'b0;
      ch_nxt       = null_cur_nxt ? LAST_CH : ptr_nxt;
    end
  end

  // Byte content of the upcoming slot.
  always_comb begin
    pid       = null_cur_nxt ? NULL_PID : BASE_PID + 13'(ch_nxt);
    cc_sel    = null_cur_nxt ? 4'd0 : cc_nxt[ch_nxt];
    data_nxt  = 8'h00;
    valid_nxt = 1'b0;
    sync_nxt  = 1'b0;
    case (state_nxt)
      S_HEADER: begin
        valid_nxt = 1'b1;
        case (byte_nxt)
          8'd0: begin
            data_nxt = 8'h47;
            sync_nxt = 1'b1;
          end
          8'd1:    data_nxt = {3'b010, pid[12:8]};
          8'd2:    data_nxt = pid[7:0];
          default: data_nxt = {4'b0001, cc_sel};
        endcase
      end
      S_PAYLOAD: begin
        valid_nxt = 1'b1;
        data_nxt  = null_cur_nxt ? 8'hFF : byte_nxt - 8'd4;
      end
      S_PARITY: data_nxt = 8'hFF;
      default:  data_nxt = 8'h00;
    endcase
  end

  // Divider runs every cycle; everything else moves only at a slot start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt  <= '0;
      state    <= S_IDLE;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      ch_ptr   <= '0;
      null_due <= 1'b0;
      null_cur <= 1'b0;
      for (int i = 0; i < 16; i++) cc[i] <= '0;
      DATA     <= '0;
      D_CLK    <= 1'b0;
      D_VALID  <= 1'b0;
      P_SYNC   <= 1'b0;
      CH_OUT   <= '0;
    end else begin
      div_cnt <= div_nxt;
      D_CLK   <= (div_nxt >= DIV_HALF);
      if (slot_tick) begin
        state    <= state_nxt;
        byte_cnt <= byte_nxt;
        gap_cnt  <= gap_nxt;
        ch_ptr   <= ptr_nxt;
        cc       <= cc_nxt;
        null_due <= null_due_nxt;
        null_cur <= null_cur_nxt;
        DATA     <= data_nxt;
        D_VALID  <= valid_nxt;
        P_SYNC   <= sync_nxt;
        CH_OUT   <= ch_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ts_multi_gen.sv
// Directed bench for ts_multi_gen: default instance (4 ch, 188 B, gap 4) and a 204 B / gap 0 / CLK_DIV 4 instance.
module tb_ts_multi_gen;

`ifdef TS_NULL_INSERT_EN
  localparam bit NULL_EN = 1'b1;
`else
  localparam bit NULL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sel = 1'b0;

  logic [7:0] a_data, b_data, s_data;
  logic       a_dclk, b_dclk, s_dclk;
  logic       a_valid, b_valid, s_valid;
  logic       a_sync, b_sync, s_sync;
  logic [3:0] a_ch, b_ch, s_ch;

  always #5 clk = ~clk;

  ts_multi_gen dut_a (
    .CLK(clk), .RST(rst), .EN(en),
    .DATA(a_data), .D_CLK(a_dclk), .D_VALID(a_valid), .P_SYNC(a_sync), .CH_OUT(a_ch)
  );

  ts_multi_gen #(
    .N_CH(2), .BASE_PID(13'h1000), .PKT_LEN(204), .GAP(0), .CLK_DIV(4)
  ) dut_b (
    .CLK(clk), .RST(rst), .EN(en),
    .DATA(b_data), .D_CLK(b_dclk), .D_VALID(b_valid), .P_SYNC(b_sync), .CH_OUT(b_ch)
  );

  always_comb begin
    s_data  = sel ? b_data  : a_data;
    s_dclk  = sel ? b_dclk  : a_dclk;
    s_valid = sel ? b_valid : a_valid;
    s_sync  = sel ? b_sync  : a_sync;
    s_ch    = sel ? b_ch    : a_ch;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pkt_buf [204];
  logic       first_sync, second_sync;
  bit         d_prev = 1'b0;
  bit         track  = 1'b0;
  int         cyc = 0, hi = 0, slot_len = 0, slot_hi = 0, n_unstable = 0;
  logic [7:0] slot_data = 8'h00;

  // Expected-sequence model
  logic [3:0]  m_ptr;
  logic [3:0]  m_cc [16];
  bit          m_null_due;
  logic [3:0]  e_ch;
  logic [12:0] e_pid;
  logic [3:0]  e_cc;
  bit          e_null;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n, input logic [12:0] pid,
                                          input logic [3:0] cc, input bit nul);
    if (n == 0) return 8'h47;
    if (n == 1) return {3'b010, pid[12:8]};
    if (n == 2) return pid[7:0];
    if (n == 3) return {4'b0001, cc};
    if (n >= 188) return 8'hFF;
    return nul ? 8'hFF : 8'(n - 4);
  endfunction

  task automatic model_reset();
    m_ptr      = '0;
    m_null_due = 1'b0;
    for (int i = 0; i < 16; i++) m_cc[i] = '0;
  endtask

  task automatic model_next(input int nch);
    if (m_null_due) begin
      e_null     = 1'b1;
      e_ch       = 4'(nch - 1);
      e_pid      = 13'h1FFF;
      e_cc       = 4'd0;
      m_null_due = 1'b0;
    end else begin
      e_null       = 1'b0;
      e_ch         = m_ptr;
      e_pid        = 13'h1000 + 13'(m_ptr);
      e_cc         = m_cc[m_ptr];
      m_cc[m_ptr]  = m_cc[m_ptr] + 4'd1;
      if (m_ptr == 4'(nch - 1)) begin
        m_ptr      = '0;
        m_null_due = NULL_EN;
      end else begin
        m_ptr = m_ptr + 4'd1;
      end
    end
  endtask

  // Advance to the next D_CLK falling edge, tracking slot length and data stability.
  task automatic next_slot();
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (s_dclk === 1'b0 && d_prev === 1'b1) begin
        found     = 1'b1;
        slot_len  = cyc;
        slot_hi   = hi;
        cyc       = 1;
        hi        = 0;
        slot_data = s_data;
        track     = 1'b1;
      end else begin
        cyc++;
        if (s_dclk === 1'b1) hi++;
        if (track && s_data !== slot_data) n_unstable++;
      end
      d_prev = s_dclk;
    end
    if (!found) begin
      check("slot_found", 32'(found), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "no byte slot boundary seen");
    end
  endtask

  task automatic run_pkt(input int len, input int gap, input int en_off_at, input int abort_at);
    int bad  = 0;
    int gbad = 0;
    for (int n = 0; n < len; n++) begin
      next_slot();
      pkt_buf[8'(n)] = s_data;
      if (n == 0) first_sync = s_sync;
      if (n == 1) second_sync = s_sync;
      if (s_data !== exp_byte(n, e_pid, e_cc, e_null) || s_valid !== (n < 188) ||
          s_sync !== (n == 0) || s_ch !== e_ch) bad++;
      if (n == en_off_at) en = 1'b0;
      if (n == abort_at) begin
        check("pkt_partial", 32'(bad), 32'd0);
        return;
      end
    end
    check("pkt_bytes", 32'(bad), 32'd0);
    check("pkt_pid", 32'({pkt_buf[1][4:0], pkt_buf[2]}), 32'(e_pid));
    check("pkt_cc", 32'(pkt_buf[3][3:0]), 32'(e_cc));
    for (int g = 0; g < gap; g++) begin
      next_slot();
      if (s_valid !== 1'b0 || s_data !== 8'h00 || s_sync !== 1'b0 || s_ch !== e_ch) gbad++;
    end
    if (gap > 0) check("gap_slots", 32'(gbad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ch2_cnt;
    logic [3:0]  last_cc2;
    int          bad;
    logic [12:0] pid_log [5];
    logic [7:0]  null_pay;

    ch2_cnt  = 0;
    last_cc2 = '0;
    null_pay = '0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_a_data", 32'(a_data), 32'h00);
    check("rst_a_dclk", 32'(a_dclk), 32'd0);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_sync", 32'(a_sync), 32'd0);
    check("rst_a_ch", 32'(a_ch), 32'd0);
    check("rst_b_data", 32'(b_data), 32'h00);
    check("rst_b_dclk", 32'(b_dclk), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);

    // First packet on the default instance
    en = 1'b1;
    model_reset();
    rst = 1'b0;
    model_next(4);
    run_pkt(188, 4, -1, -1);
    check("b0_sync", 32'(first_sync), 32'd1);
    check("b1_sync", 32'(second_sync), 32'd0);
    check("b0", 32'(pkt_buf[0]), 32'h47);
    check("b1", 32'(pkt_buf[1]), 32'h50);
    check("b2", 32'(pkt_buf[2]), 32'h00);
    check("b3", 32'(pkt_buf[3]), 32'h10);
    check("b4", 32'(pkt_buf[4]), 32'h00);
    check("b187", 32'(pkt_buf[187]), 32'hB7);
    check("slot_len_a", 32'(slot_len), 32'd2);
    check("dclk_high_a", 32'(slot_hi), 32'd1);

    // Remaining 67 packets: round robin with CC wrap on channel 2
    for (int p = 1; p < 68; p++) begin
      model_next(4);
      run_pkt(188, 4, -1, -1);
      if (s_ch == 4'd2) begin
        ch2_cnt++;
        last_cc2 = pkt_buf[3][3:0];
      end
    end
    check("ch2_count", 32'(ch2_cnt), NULL_EN ? 32'd14 : 32'd17);
    check("ch2_last_cc", 32'(last_cc2), NULL_EN ? 32'd13 : 32'd0);

    // EN dropped mid-packet: packet and gap complete, then idle
    model_next(4);
    run_pkt(188, 4, 100, -1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      next_slot();
      if (s_valid !== 1'b0 || s_data !== 8'h00 || s_sync !== 1'b0) bad++;
    end
    check("idle_after_drop", 32'(bad), 32'd0);
    en = 1'b1;
    model_next(4);
    run_pkt(188, 4, -1, -1);

    // Reset mid-packet of channel 3
    for (int p = 0; p < 8; p++) begin
      model_next(4);
      if (!e_null && e_ch == 4'd3) begin
        run_pkt(188, 4, -1, 50);
        break;
      end
      run_pkt(188, 4, -1, -1);
    end
    check("abort_ch", 32'(a_ch), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_data", 32'(a_data), 32'h00);
    check("abort_valid", 32'(a_valid), 32'd0);
    check("abort_sync", 32'(a_sync), 32'd0);
    check("abort_dclk", 32'(a_dclk), 32'd0);
    check("abort_chout", 32'(a_ch), 32'd0);
    track  = 1'b0;
    d_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_next(4);
    run_pkt(188, 4, -1, -1);
    check("post_rst_pid", 32'({pkt_buf[1][4:0], pkt_buf[2]}), 32'h1000);
    check("post_rst_cc", 32'(pkt_buf[3][3:0]), 32'd0);

    // 204-byte, gap 0, two channels
    rst = 1'b1;
    sel = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    track  = 1'b0;
    d_prev = 1'b0;
    rst    = 1'b0;
    model_reset();
    for (int p = 0; p < 5; p++) begin
      model_next(2);
      run_pkt(204, 0, -1, -1);
      pid_log[p] = {pkt_buf[1][4:0], pkt_buf[2]};
      if (p == 2) null_pay = pkt_buf[100];
      if (p == 0) begin
        check("parity_188", 32'(pkt_buf[188]), 32'hFF);
        check("parity_203", 32'(pkt_buf[203]), 32'hFF);
      end
    end
    check("slot_len_b", 32'(slot_len), 32'd4);
    check("dclk_high_b", 32'(slot_hi), 32'd2);
    check("seq_pid0", 32'(pid_log[0]), 32'h1000);
    check("seq_pid1", 32'(pid_log[1]), 32'h1001);
    check("seq_pid2", 32'(pid_log[2]), NULL_EN ? 32'h1FFF : 32'h1000);
    check("seq_pid3", 32'(pid_log[3]), NULL_EN ? 32'h1000 : 32'h1001);
    check("pkt2_pay100", 32'(null_pay), NULL_EN ? 32'hFF : 32'h60);
    check("data_stable", 32'(n_unstable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
